lsu_mem_interface: RTL and testbench
====================================

Name: lsu_mem_interface

Overview:
- Load/store unit sitting directly downstream of the main decoder, between the datapath and data memory.
- Consumes the decoder's MemWrite, Store[1:0] and Load[2:0] controls, plus a mem_read strobe (ResultSrc==01), the ALU address and rs2 data.
- Drives a variable-latency req/ack data-memory port with byte enables and lane-replicated write data.
- Stalls the single-cycle core until the access completes, then returns the sign/zero-extended load result; also detects misalignment and memory timeout.

Parameters:
- TIMEOUT, 16, BUSY cycles without dmem_ack before the access is aborted with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load instruction present (ResultSrc==01)
- mem_write  in  1  store instruction present (decoder MemWrite)
- store_sel  in  2  decoder Store: 00 sw, 01 sb, 10 sh
- load_sel  in  3  decoder Load: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC and the register file this cycle
- rdata  out  32  extended load result, valid in the RESP cycle
- misalign  out  1  combinational: current access is misaligned and was suppressed
- bus_err  out  1  one-cycle pulse in RESP when the access timed out
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  memory completion; read data valid in the same cycle
- dmem_rdata  in  32  memory read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, rdata, bus_err all 0. Reset mid-access drops dmem_req immediately; the access is abandoned.
- Access = mem_read|mem_write. If both are set, mem_write wins.
- Misalignment: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0. Byte accesses are never misaligned.
  - A misaligned access sets misalign=1 combinationally, issues no request, keeps stall=0 and suppresses the write.
- FSM states:
  - IDLE:
    - stall = access & !misalign.
    - On that condition, register dmem_addr, dmem_be, dmem_wdata, dmem_we, load_sel and addr[1:0]; clear the counter; go to BUSY.
  - BUSY:
    - dmem_req=1, stall=1; all dmem_* outputs held stable.
    - If dmem_ack=1: capture the extended load result into rdata (reads only) and go to RESP.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set bus_err, set rdata=0, go to RESP.
    - Else increment the counter.
  - RESP:
    - dmem_req=0, stall=0; the core retires the instruction at this edge.
    - bus_err is high only in this cycle if a timeout occurred.
    - Always returns to IDLE.
    - Decoder inputs still show the retiring instruction, so RESP never launches a new access.
- dmem_req deasserts in the cycle after ack, when the FSM is in RESP.
- dmem_ack outside BUSY is ignored.
- Latency: a zero-wait memory (ack in the first BUSY cycle) gives 2 stall cycles and 3 cycles total per access. Each extra wait cycle adds one stall cycle.
- Byte enables and write data:
  - sb: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
  - sh: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}
  - sw: be=4'b1111, wdata unchanged
  - Loads: be by the same width rule, dmem_we=0.
- Load extract:
  - byte = dmem_rdata[8*off +: 8]; half = dmem_rdata[16*off[1] +: 16], where off is the latched addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
  - An undefined load_sel acts as lw.
- rdata holds its value until the next load completes; stores do not modify it.
- Counter width: $clog2(TIMEOUT+1) bits (minimum 1).

Test Plan:
- sb, addr=0x1003, wdata=0x000000AB, ack in first BUSY cycle -> dmem_be=4'b1000, dmem_wdata=0xABABABAB, dmem_addr=0x1000, dmem_we=1; stall high 2 cycles, low in RESP.
- lb, addr=0x2002, dmem_rdata=0x00FF0000 -> rdata=0xFFFFFFFF; repeat as lbu -> 0x000000FF; lhu at 0x2002 with rdata 0x8001xxxx -> 0x00008001; lh -> 0xFFFF8001.
- lh at 0x2001 -> misalign=1, stall=0, dmem_req never rises; sw at 0x3002 -> misalign=1, no write issued.
- lw with ack delayed 3 cycles after req -> stall high 5 cycles, dmem_addr/be stable throughout BUSY, rdata equals dmem_rdata in RESP.
- TIMEOUT=4, no ack -> exactly 4 BUSY cycles, then RESP with bus_err=1 (one cycle) and rdata=0; FSM back in IDLE the following cycle.
- rst_n pulsed low during BUSY (asynchronous to clk) -> dmem_req, stall and all outputs 0 immediately; a subsequent lw completes normally.

Source files
------------

// File: rtl/lsu_mem_interface_if.sv
// Data-memory port between the load/store unit and a variable-latency memory.
// req is held high until ack; read data is valid in the ack cycle.
interface lsu_mem_interface_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_interface.sv
// Load/store unit: stalls the single-cycle core over a req/ack memory access and returns extended loads.
// Latency: 1 IDLE + N BUSY stall cycles, then RESP; misaligned accesses are dropped without stalling.
module lsu_mem_interface #(
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  input  logic [1:0]             store_sel_i,
  input  logic [2:0]             load_sel_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   stall_o,
  output logic [31:0]            rdata_o,
  output logic                   misalign_o,
  output logic                   bus_err_o,
  lsu_mem_interface_if.master    dmem
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    lsel_q;
  logic [1:0]    off_q;
  logic [31:0]   rdata_q;
  logic          bus_err_q;

  logic        access;
  logic        bad_align;
  logic        start;
  logic [1:0]  size;       // 0 byte, 1 half, 2 word
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;

  assign access = mem_read_i | mem_write_i;

  // Stores take precedence when both strobes are set; undefined selects act as word.
  always_comb begin
    size = 2'd2;
    if (mem_write_i) begin
      case (store_sel_i)
        2'b01:   size = 2'd0;
        2'b10:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (load_sel_i)
        3'b000, 3'b011: size = 2'd0;
        3'b001, 3'b100: size = 2'd1;
        default:        size = 2'd2;
      endcase
    end
  end

  assign bad_align = ((size == 2'd1) && addr_i[0]) ||
                     ((size == 2'd2) && (addr_i[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (size)
      2'd0: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  assign start      = (state_q == S_IDLE) && access && !bad_align;
  assign misalign_o = (state_q == S_IDLE) && access && bad_align;
  // Reset gating keeps the core unstalled while the LSU is held in reset.
  assign stall_o    = rst_n && (start || (state_q == S_BUSY));

  always_comb begin
    byte_v   = 8'(dmem.dmem_rdata >> {off_q, 3'b000});
    half_v   = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    load_val = dmem.dmem_rdata;
    case (lsel_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b011:  load_val = {24'd0, byte_v};
      3'b100:  load_val = {16'd0, half_v};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      lsel_q    <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= mem_write_i;
            lsel_q  <= load_sel_i;
            off_q   <= addr_i[1:0];
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem.dmem_ack) begin
            if (!we_q) rdata_q <= load_val;
            state_q <= S_RESP;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            bus_err_q <= 1'b1;
            rdata_q   <= '0;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // The decoder still shows the retiring instruction here, so never relaunch.
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = (state_q == S_BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign rdata_o         = rdata_q;
  assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Directed bench for lsu_mem_interface (TIMEOUT=4) with a bench-driven memory responder.
module tb_lsu_mem_interface;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  store_sel;
  logic [2:0]  load_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  lsu_mem_interface_if ifc ();

  lsu_mem_interface #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read_i  (mem_read),
    .mem_write_i (mem_write),
    .store_sel_i (store_sel),
    .load_sel_i  (load_sel),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall_o     (stall),
    .rdata_o     (rdata),
    .misalign_o  (misalign),
    .bus_err_o   (bus_err),
    .dmem        (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    store_sel = 2'b00;
    load_sel  = 3'b000;
    addr      = '0;
    wdata     = '0;
  endtask

  // Drives one access from IDLE, acks after ack_dly BUSY cycles (negative: never),
  // and records what the memory port showed plus the RESP-cycle result.
  task automatic run_access(
    input  string       tag,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  ss,
    input  logic [2:0]  ls,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rword,
    input  int          ack_dly,
    output int          n_stall,
    output int          n_busy,
    output logic [31:0] o_addr,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_we,
    output logic        o_stable,
    output logic [31:0] o_rdata,
    output logic        o_err
  );
    bit seen;
    bit done;
    n_stall  = 0;
    n_busy   = 0;
    o_addr   = '0;
    o_be     = '0;
    o_wdata  = '0;
    o_we     = 1'b0;
    o_stable = 1'b1;
    o_rdata  = '0;
    o_err    = 1'b0;
    seen     = 0;
    done     = 0;
    @(posedge clk); #1;
    mem_read       = rd;
    mem_write      = wr;
    store_sel      = ss;
    load_sel       = ls;
    addr           = a;
    wdata          = wd;
    ifc.dmem_rdata = rword;
    ifc.dmem_ack   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (ifc.dmem_req) begin
        n_busy++;
        if (!seen) begin
          o_addr  = ifc.dmem_addr;
          o_be    = ifc.dmem_be;
          o_wdata = ifc.dmem_wdata;
          o_we    = ifc.dmem_we;
        end else if (o_addr !== ifc.dmem_addr || o_be !== ifc.dmem_be ||
                     o_wdata !== ifc.dmem_wdata || o_we !== ifc.dmem_we) begin
          o_stable = 1'b0;
        end
        seen = 1;
        ifc.dmem_ack = (ack_dly >= 0) && (n_busy > ack_dly);
      end else if (seen) begin
        o_rdata      = rdata;
        o_err        = bus_err;
        ifc.dmem_ack = 1'b0;
        done         = 1;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  int          ns, nb;
  logic [31:0] oa, ow, ord;
  logic [3:0]  obe;
  logic        owe, ost, oerr;
  bit          req_seen;

  initial begin
    clear_inputs();
    ifc.dmem_ack   = 1'b0;
    ifc.dmem_rdata = '0;
    rst_n = 1'b0;
    #23;
    check("rst_req",    32'(ifc.dmem_req), 32'd0);
    check("rst_stall",  32'(stall),        32'd0);
    check("rst_be",     32'(ifc.dmem_be),  32'd0);
    check("rst_rdata",  rdata,             32'd0);
    check("rst_buserr", 32'(bus_err),      32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // sb 0x1003, zero-wait memory
    run_access("sb", 1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'h0000_00AB,
               32'h0, 0, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("sb_be",    32'(obe), 32'h8);
    check("sb_wdata", ow,       32'hABAB_ABAB);
    check("sb_addr",  oa,       32'h0000_1000);
    check("sb_we",    32'(owe), 32'd1);
    check("sb_stall", 32'(ns),  32'd2);

    run_access("lb", 1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_2002, 32'h0,
               32'h00FF_0000, 0, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("lb_rdata", ord,      32'hFFFF_FFFF);
    check("lb_be",    32'(obe), 32'h4);
    check("lb_we",    32'(owe), 32'd0);

    run_access("lbu", 1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_2002, 32'h0,
               32'h00FF_0000, 0, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("lbu_rdata", ord, 32'h0000_00FF);

    run_access("lhu", 1'b1, 1'b0, 2'b00, 3'b100, 32'h0000_2002, 32'h0,
               32'h8001_1234, 0, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("lhu_rdata", ord,      32'h0000_8001);
    check("lhu_be",    32'(obe), 32'hC);

    run_access("lh", 1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'h0,
               32'h8001_1234, 0, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("lh_rdata", ord, 32'hFFFF_8001);

    // Misaligned lh: no stall, no request
    @(posedge clk); #1;
    mem_read = 1'b1; load_sel = 3'b001; addr = 32'h0000_2001;
    req_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ifc.dmem_req) req_seen = 1;
    end
    check("mis_lh_flag",  32'(misalign), 32'd1);
    check("mis_lh_stall", 32'(stall),    32'd0);
    check("mis_lh_req",   32'(req_seen), 32'd0);
    @(posedge clk); #1;
    clear_inputs();

    // Misaligned sw: no write issued
    mem_write = 1'b1; store_sel = 2'b00; addr = 32'h0000_3002; wdata = 32'h1111_2222;
    req_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ifc.dmem_req) req_seen = 1;
    end
    check("mis_sw_flag", 32'(misalign), 32'd1);
    check("mis_sw_req",  32'(req_seen), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("mis_clear", 32'(misalign), 32'd0);

    // lw with three wait cycles
    run_access("lw_wait", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_4000, 32'h0,
               32'hDEAD_BEEF, 3, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("lw_wait_stall",  32'(ns),  32'd5);
    check("lw_wait_busy",   32'(nb),  32'd4);
    check("lw_wait_stable", 32'(ost), 32'd1);
    check("lw_wait_be",     32'(obe), 32'hF);
    check("lw_wait_rdata",  ord,      32'hDEAD_BEEF);

    // sh must leave rdata untouched
    run_access("sh", 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_6002, 32'h1234_ABCD,
               32'h5555_5555, 1, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("sh_be",    32'(obe), 32'hC);
    check("sh_wdata", ow,       32'hABCD_ABCD);
    check("sh_hold",  ord,      32'hDEAD_BEEF);
    check("sh_stall", 32'(ns),  32'd3);

    // Both strobes: write wins
    run_access("rw", 1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_7000, 32'hCAFE_F00D,
               32'h0, 0, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("rw_we",    32'(owe), 32'd1);
    check("rw_wdata", ow,       32'hCAFE_F00D);
    check("rw_be",    32'(obe), 32'hF);

    // Asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    mem_read = 1'b1; load_sel = 3'b010; addr = 32'h0000_8000;
    ifc.dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_req", 32'(ifc.dmem_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req",   32'(ifc.dmem_req),  32'd0);
    check("arst_stall", 32'(stall),         32'd0);
    check("arst_addr",  ifc.dmem_addr,      32'd0);
    check("arst_be",    32'(ifc.dmem_be),   32'd0);
    check("arst_wdata", ifc.dmem_wdata,     32'd0);
    check("arst_rdata", rdata,              32'd0);
    clear_inputs();
    @(negedge clk); #2;
    rst_n = 1'b1;

    run_access("lw_post", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_9004, 32'h0,
               32'h1357_2468, 1, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("lw_post_rdata", ord, 32'h1357_2468);
    check("lw_post_addr",  oa,  32'h0000_9004);

    // Timeout: no ack ever
    run_access("to", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_A000, 32'h0,
               32'hFFFF_0000, -1, ns, nb, oa, obe, ow, owe, ost, ord, oerr);
    check("to_busy",   32'(nb),   32'd4);
    check("to_buserr", 32'(oerr), 32'd1);
    check("to_rdata",  ord,       32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(bus_err),      32'd0);
    check("to_idle_req",  32'(ifc.dmem_req), 32'd0);
    check("to_idle_stall",32'(stall),        32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
